// File: rtl/poa_pkg.sv
// Shared types and constants for the proof-of-authority round scheduler.
package poa_pkg;

  typedef struct packed {
    logic [255:0] prev_hash;
    logic [31:0]  timestamp;
    logic [255:0] block_hash;
  } block_content_input;

  localparam int NUM_TABLE = 3;

  // Authorized signer IDs, indexed by turn.
  localparam logic [NUM_TABLE-1:0][31:0] VALIDATORS = {32'd3, 32'd2, 32'd1};

  localparam logic [1:0] REJ_NONE      = 2'd0;
  localparam logic [1:0] REJ_PREV_HASH = 2'd1;
  localparam logic [1:0] REJ_STALE_TS  = 2'd2;
  localparam logic [1:0] REJ_NO_SIGNER = 2'd3;

endpackage

// File: rtl/poa_slot_timer.sv
// Per-slot signature timeout: down-counter that flags the last cycle of a slot.
module poa_slot_timer #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [W-1:0] LOAD = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] count;

  assign expired = en && (count == '0);

  always_ff @(posedge clk) begin
    if (reset || clr || expired) count <= LOAD;
    else if (en)                 count <= count - 1'b1;
  end

endmodule

// File: rtl/poa_round_scheduler.sv
// Round-robin PoA block scheduler: validates a proposal, collects one signature
// from the validator whose turn it is, and appends the block to the chain tip.
//
// state     | meaning
// IDLE      | waiting for a proposal (prop_ready=1)
// CHECK     | prev-hash / timestamp validation of the captured proposal
// SIGN_WAIT | requesting a signature from VALIDATORS[turn]
// COMMIT    | commit pulse visible, chain registers already updated
module poa_round_scheduler
  import poa_pkg::*;
#(
  parameter int           NUM_VALIDATORS = 3,
  parameter int           TIMEOUT_CYCLES = 16,
  parameter logic [255:0] GENESIS_HASH   = 256'habc123456
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               prop_valid,
  output logic               prop_ready,
  input  block_content_input prop_content,
  output logic               sign_req,
  output logic [31:0]        sign_id,
  input  logic               sign_ack,
  input  logic [31:0]        sign_ack_id,
  output logic               commit_valid,
  output logic [255:0]       commit_hash,
  output logic [31:0]        commit_height,
  output logic [31:0]        commit_validator,
  output logic               reject,
  output logic [1:0]         reject_code
);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_CHECK     = 2'd1;
  localparam logic [1:0] S_SIGN_WAIT = 2'd2;
  localparam logic [1:0] S_COMMIT    = 2'd3;

  localparam int TW = (NUM_VALIDATORS > 1) ? $clog2(NUM_VALIDATORS) : 1;
  localparam int SW = $clog2(NUM_VALIDATORS + 1);

  logic [1:0]         state;
  block_content_input prop;
  logic [TW-1:0]      turn;
  logic [SW-1:0]      skips;
  logic [255:0]       last_hash;
  logic [31:0]        last_ts;
  logic [31:0]        height;
  logic               ack_ok;
  logic               expired;

  function automatic logic [TW-1:0] next_turn(input logic [TW-1:0] t);
    return (t == TW'(NUM_VALIDATORS - 1)) ? '0 : t + 1'b1;
  endfunction

  assign prop_ready    = (state == S_IDLE);
  assign sign_req      = (state == S_SIGN_WAIT);
  assign sign_id       = sign_req ? VALIDATORS[turn] : 32'd0;
  assign ack_ok        = sign_req && sign_ack && (sign_ack_id == sign_id);
  assign commit_hash   = last_hash;
  assign commit_height = height;

  // A matching ack holds the timer, so an ack on the expiring cycle never skips.
  poa_slot_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_slot_timer (
    .clk     (clk),
    .reset   (reset),
    .clr     (state != S_SIGN_WAIT),
    .en      (sign_req && !ack_ok),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= S_IDLE;
      prop             <= '0;
      turn             <= '0;
      skips            <= '0;
      height           <= '0;
      last_hash        <= GENESIS_HASH;
      last_ts          <= '0;
      commit_valid     <= 1'b0;
      commit_validator <= '0;
      reject           <= 1'b0;
      reject_code      <= REJ_NONE;
    end else begin
      commit_valid <= 1'b0;
      reject       <= 1'b0;
      reject_code  <= REJ_NONE;
      case (state)
        S_IDLE: begin
          if (prop_valid) begin
            prop  <= prop_content;
            state <= S_CHECK;
          end
        end
        S_CHECK: begin
          skips <= '0;
          if (prop.prev_hash != last_hash) begin
            reject      <= 1'b1;
            reject_code <= REJ_PREV_HASH;
            state       <= S_IDLE;
          end else if (prop.timestamp <= last_ts) begin
            reject      <= 1'b1;
            reject_code <= REJ_STALE_TS;
            state       <= S_IDLE;
          end else begin
            state <= S_SIGN_WAIT;
          end
        end
        S_SIGN_WAIT: begin
          // Chain registers update on the way into COMMIT so the pulse shows the new tip.
          if (ack_ok) begin
            commit_valid     <= 1'b1;
            commit_validator <= sign_id;
            last_hash        <= prop.block_hash;
            last_ts          <= prop.timestamp;
            height           <= height + 1'b1;
            turn             <= next_turn(turn);
            state            <= S_COMMIT;
          end else if (expired) begin
            turn  <= next_turn(turn);
            skips <= skips + 1'b1;
            if (skips == SW'(NUM_VALIDATORS - 1)) begin
              reject      <= 1'b1;
              reject_code <= REJ_NO_SIGNER;
              state       <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_poa_round_scheduler.sv
// Bench for poa_round_scheduler: proposal-level reference model plus per-cycle compare.
module tb_poa_round_scheduler;
  import poa_pkg::*;

  localparam int TO = 16;
  localparam int NV = 3;
  localparam logic [255:0] GEN = 256'habc123456;

  logic               clk;
  logic               reset;
  logic               prop_valid;
  logic               prop_ready;
  block_content_input prop_content;
  logic               sign_req;
  logic [31:0]        sign_id;
  logic               sign_ack;
  logic [31:0]        sign_ack_id;
  logic               commit_valid;
  logic [255:0]       commit_hash;
  logic [31:0]        commit_height;
  logic [31:0]        commit_validator;
  logic               reject;
  logic [1:0]         reject_code;

  poa_round_scheduler dut (
    .clk              (clk),
    .reset            (reset),
    .prop_valid       (prop_valid),
    .prop_ready       (prop_ready),
    .prop_content     (prop_content),
    .sign_req         (sign_req),
    .sign_id          (sign_id),
    .sign_ack         (sign_ack),
    .sign_ack_id      (sign_ack_id),
    .commit_valid     (commit_valid),
    .commit_hash      (commit_hash),
    .commit_height    (commit_height),
    .commit_validator (commit_validator),
    .reject           (reject),
    .reject_code      (reject_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference chain state and expected per-cycle outputs.
  logic [255:0] m_hash;
  logic [31:0]  m_ts, m_height, m_val;
  int           m_turn;
  bit           exp_valid;
  logic         exp_ready, exp_sreq, exp_cv, exp_rj;
  logic [31:0]  exp_sid;
  logic [1:0]   exp_rc;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (exp_valid) begin
      check("prop_ready", prop_ready, exp_ready);
      check("sign_req", sign_req, exp_sreq);
      check("sign_id", sign_id, exp_sid);
      check("commit_valid", commit_valid, exp_cv);
      check("reject", reject, exp_rj);
      check("reject_code", reject_code, exp_rc);
      check("commit_hash", commit_hash, m_hash);
      check("commit_height", commit_height, m_height);
      check("commit_validator", commit_validator, m_val);
    end
  end

  function automatic logic [31:0] vid(input int i);
    return 32'((i % NV) + 1);
  endfunction

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_exp(input logic rdy, input logic sreq, input logic [31:0] sid,
                         input logic cv, input logic rj, input logic [1:0] rc);
    exp_ready = rdy; exp_sreq = sreq; exp_sid = sid;
    exp_cv = cv; exp_rj = rj; exp_rc = rc;
  endtask

  task automatic model_reset();
    m_hash = GEN; m_ts = 0; m_height = 0; m_val = 0; m_turn = 0;
  endtask

  // Drives one proposal from an IDLE cycle; returns in the next IDLE cycle.
  task automatic run_prop(input logic [255:0] prev, input logic [31:0] ts, input logic [255:0] h,
                          input int k_ack, input int rst_at, input bit noise,
                          output int lat, output logic [1:0] rc_seen, output logic [31:0] first_sid);
    int code;
    int t0;
    logic [31:0] want;
    lat = -1; rc_seen = 0; first_sid = 0;
    prop_valid = 1'b1;
    prop_content = '{prev_hash: prev, timestamp: ts, block_hash: h};
    step();
    prop_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    prop_content = rnd256();
    set_exp(0, 0, 0, 0, 0, 0);
    code = (prev !== m_hash) ? 1 : ((ts <= m_ts) ? 2 : 0);
    step();
    prop_valid = 1'b0;
    if (code != 0) begin
      set_exp(1, 0, 0, 0, 1, 2'(code));
      if (reject || commit_valid) lat = 2;
      rc_seen = reject_code;
      step();
      set_exp(1, 0, 0, 0, 0, 0);
      return;
    end
    t0 = m_turn;
    for (int k = 0; k < NV * TO; k++) begin
      want = vid(t0 + k / TO);
      set_exp(0, 1, want, 0, 0, 0);
      if (k == 0) first_sid = sign_id;
      if (k == rst_at) begin
        sign_ack = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        model_reset();
        set_exp(1, 0, 0, 0, 0, 0);
        return;
      end
      if (k == k_ack) begin
        sign_ack = 1'b1; sign_ack_id = want;
      end else if (noise && ($urandom_range(0, 2) == 0)) begin
        sign_ack = 1'b1; sign_ack_id = want + 32'($urandom_range(1, 3));
      end else begin
        sign_ack = 1'b0; sign_ack_id = $urandom;
      end
      step();
      if (k == k_ack) begin
        sign_ack = 1'b0;
        m_hash = h; m_ts = ts; m_height = m_height + 1; m_val = want;
        m_turn = (t0 + k / TO + 1) % NV;
        set_exp(0, 0, 0, 1, 0, 0);
        if (reject || commit_valid) lat = 3 + k;
        step();
        set_exp(1, 0, 0, 0, 0, 0);
        return;
      end
    end
    sign_ack = 1'b0;
    set_exp(1, 0, 0, 0, 1, 2'd3);
    if (reject || commit_valid) lat = 2 + NV * TO;
    rc_seen = reject_code;
    step();
    set_exp(1, 0, 0, 0, 0, 0);
  endtask

  int lat;
  logic [1:0] rc;
  logic [31:0] fsid;
  logic [255:0] h1, h2, h3, h4, h5;

  initial begin
    exp_valid = 0;
    reset = 1'b1; prop_valid = 1'b0; prop_content = '0; sign_ack = 1'b0; sign_ack_id = '0;
    model_reset();
    set_exp(1, 0, 0, 0, 0, 0);
    h1 = rnd256(); h2 = rnd256(); h3 = rnd256(); h4 = rnd256(); h5 = rnd256();
    step();
    step();
    reset = 1'b0;
    exp_valid = 1;
    check("rst_commit_hash", commit_hash, 256'habc123456);
    check("rst_prop_ready", prop_ready, 1);
    check("rst_height", commit_height, 0);

    run_prop(GEN, 10, h1, 2, -1, 0, lat, rc, fsid);
    check("first_commit_height", commit_height, 1);
    check("first_commit_validator", commit_validator, 1);
    check("first_commit_latency", lat, 5);

    run_prop(~GEN, 20, h2, 0, -1, 0, lat, rc, fsid);
    check("bad_prev_code", rc, 1);
    check("bad_prev_latency", lat, 2);
    check("bad_prev_height", commit_height, 1);

    run_prop(h1, 10, h2, 0, -1, 0, lat, rc, fsid);
    check("stale_ts_code", rc, 2);

    run_prop(h1, 11, h3, TO, -1, 0, lat, rc, fsid);
    check("turn_after_first_commit", fsid, 2);
    check("skip_commit_validator", commit_validator, 3);

    run_prop(h3, 12, h4, -1, -1, 1, lat, rc, fsid);
    check("no_signer_code", rc, 3);
    check("no_signer_first_sid", fsid, 1);
    check("no_signer_latency", lat, 50);

    run_prop(h3, 12, h4, TO - 1, -1, 1, lat, rc, fsid);
    check("ack_at_timeout_validator", commit_validator, 1);
    check("ack_at_timeout_height", commit_height, 3);

    run_prop(h4, 13, h5, 0, -1, 0, lat, rc, fsid);
    check("min_latency", lat, 3);
    check("min_latency_validator", commit_validator, 2);

    run_prop(h5, 14, rnd256(), -1, 5, 0, lat, rc, fsid);
    check("reset_mid_height", commit_height, 0);
    check("reset_mid_hash", commit_hash, 256'habc123456);
    check("reset_mid_ready", prop_ready, 1);

    for (int n = 0; n < 40; n++) begin
      logic [255:0] prev;
      int gap, ka, ra;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        sign_ack = 1'($urandom_range(0, 1)); sign_ack_id = $urandom_range(0, 4);
        step();
      end
      sign_ack = 1'b0;
      prev = ($urandom_range(0, 99) < 85) ? m_hash : rnd256();
      ka = ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(0, NV * TO - 1));
      ra = ($urandom_range(0, 14) == 0) ? int'($urandom_range(0, NV * TO - 1)) : -1;
      run_prop(prev, m_ts + 32'($urandom_range(0, 3)), rnd256(), ka, ra, 1, lat, rc, fsid);
    end

    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
